// File: rtl/midi_note_tracker.sv
// rtl/midi_note_tracker.sv - MIDI note-on/off parser feeding a 10-slot sounding-note table
//
// Purpose: consumes bytes from the MIDI UART receiver, parses note-on/note-off
// messages (with running status) and keeps a table of currently sounding notes
// packed onto received_note for the staff renderer.
//
// Ports:
//   clk_camera_in  in   system clock, rising edge
//   rst_in         in   asynchronous active-low reset
//   midi_byte_in   in   [7:0] received MIDI byte
//   midi_valid_in  in   one-cycle strobe qualifying midi_byte_in
//   received_note  out  [8*NUM_SLOTS-1:0] slot i = bits [8i+7:8i], {active, note[6:0]}
//   note_count     out  [3:0] number of active slots
//   note_update    out  one-cycle pulse when received_note changes
//   overflow       out  one-cycle pulse when a note-on is dropped (table full)
//
// Optional feature macro: MIDI_SUSTAIN_PEDAL_EN (controller 64 sustain handling)

module midi_note_tracker #(
    parameter int CHANNEL   = 0,
    parameter int NUM_SLOTS = 10
) (
    input  logic                   clk_camera_in,
    input  logic                   rst_in,
    input  logic [7:0]             midi_byte_in,
    input  logic                   midi_valid_in,
    output logic [8*NUM_SLOTS-1:0] received_note,
    output logic [3:0]             note_count,
    output logic                   note_update,
    output logic                   overflow
);

    localparam int         IW   = $clog2(NUM_SLOTS);
    localparam bit         OMNI = (CHANNEL == 16);
    localparam logic [3:0] CH4  = CHANNEL[3:0];

    typedef enum logic [1:0] {S_IDLE, S_DATA1, S_DATA2} state_t;

    state_t      r_state, w_state_next;
    logic        r_rs_valid, w_rs_valid_next;
    // Bits [5:4] of the running status byte: 00 note-off, 01 note-on, 11 control change.
    logic [1:0]  r_rs_hi, w_rs_hi_next;
    logic [6:0]  r_note, w_note_next;
    logic [7:0]  r_slot [NUM_SLOTS];
    logic [7:0]  w_slot_next [NUM_SLOTS];
    logic        r_update, w_update_next;
    logic        r_overflow, w_overflow_next;
`ifdef MIDI_SUSTAIN_PEDAL_EN
    logic                 r_sustain, w_sustain_next;
    logic [NUM_SLOTS-1:0] r_pending, w_pending_next;
`endif

    logic          w_realtime, w_accept, w_commit;
    logic [6:0]    w_vel;
    logic          w_hit, w_free;
    logic [IW-1:0] w_hit_idx, w_free_idx;
    logic [3:0]    w_count;

    assign w_realtime = (midi_byte_in >= 8'hF8);
    assign w_vel      = midi_byte_in[6:0];
    assign w_commit   = midi_valid_in && !midi_byte_in[7] && (r_state == S_DATA2);

    always_comb begin
        w_accept = 1'b0;
        if (midi_byte_in[7:4] == 4'h8 || midi_byte_in[7:4] == 4'h9)
            w_accept = 1'b1;
`ifdef MIDI_SUSTAIN_PEDAL_EN
        if (midi_byte_in[7:4] == 4'hB)
            w_accept = 1'b1;
`endif
        w_accept = w_accept && (OMNI || midi_byte_in[3:0] == CH4);
    end

    // Slot search: the slot already holding r_note, and the lowest inactive slot.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (r_slot[i][7] && r_slot[i][6:0] == r_note) begin
                w_hit     = 1'b1;
                w_hit_idx = i[IW-1:0];
            end
            if (!r_slot[i][7]) begin
                w_free     = 1'b1;
                w_free_idx = i[IW-1:0];
            end
        end
    end

    // Parser next state; real-time bytes leave everything untouched.
    always_comb begin
        w_state_next    = r_state;
        w_rs_valid_next = r_rs_valid;
        w_rs_hi_next    = r_rs_hi;
        w_note_next     = r_note;
        if (midi_valid_in && !w_realtime) begin
            if (midi_byte_in[7]) begin
                if (w_accept) begin
                    w_rs_valid_next = 1'b1;
                    w_rs_hi_next    = midi_byte_in[5:4];
                    w_state_next    = S_DATA1;
                end else begin
                    w_rs_valid_next = 1'b0;
                    w_state_next    = S_IDLE;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_rs_valid) begin
                            w_note_next  = midi_byte_in[6:0];
                            w_state_next = S_DATA2;
                        end
                    end
                    S_DATA1: begin
                        w_note_next  = midi_byte_in[6:0];
                        w_state_next = S_DATA2;
                    end
                    S_DATA2: w_state_next = S_DATA1;
                    default: w_state_next = S_IDLE;
                endcase
            end
        end
    end

    // Table update on the velocity byte.
    always_comb begin
        w_slot_next     = r_slot;
        w_update_next   = 1'b0;
        w_overflow_next = 1'b0;
`ifdef MIDI_SUSTAIN_PEDAL_EN
        w_sustain_next  = r_sustain;
        w_pending_next  = r_pending;
`endif
        if (w_commit) begin
            if (r_rs_hi == 2'b11) begin
`ifdef MIDI_SUSTAIN_PEDAL_EN
                if (r_note == 7'd64) begin
                    w_sustain_next = w_vel[6];
                    // Pedal release drops every held note at once.
                    if (r_sustain && !w_vel[6] && (|r_pending)) begin
                        for (int i = 0; i < NUM_SLOTS; i++)
                            if (r_pending[i])
                                w_slot_next[i] = 8'h00;
                        w_pending_next = '0;
                        w_update_next  = 1'b1;
                    end
                end
`endif
            end else if (r_rs_hi == 2'b01 && w_vel != 7'd0) begin
                if (w_hit) begin
`ifdef MIDI_SUSTAIN_PEDAL_EN
                    w_pending_next[w_hit_idx] = 1'b0;
`endif
                end else if (w_free) begin
                    w_slot_next[w_free_idx] = {1'b1, r_note};
                    w_update_next           = 1'b1;
                end else begin
                    w_overflow_next = 1'b1;
                end
            end else if (w_hit) begin
`ifdef MIDI_SUSTAIN_PEDAL_EN
                if (r_sustain) begin
                    w_pending_next[w_hit_idx] = 1'b1;
                end else begin
                    w_slot_next[w_hit_idx] = 8'h00;
                    w_update_next          = 1'b1;
                end
`else
                w_slot_next[w_hit_idx] = 8'h00;
                w_update_next          = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk_camera_in or negedge rst_in) begin
        if (!rst_in)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk_camera_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rs_valid <= 1'b0;
            r_rs_hi    <= 2'b00;
            r_note     <= 7'd0;
            r_update   <= 1'b0;
            r_overflow <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++)
                r_slot[i] <= 8'h00;
`ifdef MIDI_SUSTAIN_PEDAL_EN
            r_sustain  <= 1'b0;
            r_pending  <= '0;
`endif
        end else begin
            r_rs_valid <= w_rs_valid_next;
            r_rs_hi    <= w_rs_hi_next;
            r_note     <= w_note_next;
            r_update   <= w_update_next;
            r_overflow <= w_overflow_next;
            for (int i = 0; i < NUM_SLOTS; i++)
                r_slot[i] <= w_slot_next[i];
`ifdef MIDI_SUSTAIN_PEDAL_EN
            r_sustain  <= w_sustain_next;
            r_pending  <= w_pending_next;
`endif
        end
    end

    always_comb begin
        w_count = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++)
            w_count = w_count + {3'b000, r_slot[i][7]};
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SLOTS; g++) begin : g_pack
            assign received_note[8*g +: 8] = r_slot[g];
        end
    endgenerate

    assign note_count  = w_count;
    assign note_update = r_update;
    assign overflow    = r_overflow;

endmodule
